pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, PC/address width.
REQ-002 Parameter RESET_VEC, default 32'h0, PC value loaded on reset.
REQ-003 Parameter NUM_REDIR, default 2, number of redirect channels; index 0 has highest priority.
REQ-004 Parameter HOLD_W, default 3, width of hold_flag_i.
REQ-005 Parameter HOLD_PC_LVL, default 1; PC is held when hold_flag_i >= this value.
REQ-006 Parameter C_EXT, default 0; 1 enables 16-bit instruction stepping and 2-byte alignment.
REQ-007 Parameter BOOT_CYCLES, default 2, fetch-disabled cycles after reset (0 allowed).
REQ-008 clk  input  1  clock; all state updates on its rising edge.
REQ-009 rst  input  1  reset; synchronous, active-high.
REQ-010 redir_valid_i  input  NUM_REDIR  per-channel redirect request.
REQ-011 redir_addr_i  input  NUM_REDIR*ADDR_W  redirect targets; channel k occupies bits [k*ADDR_W +: ADDR_W].
REQ-012 hold_flag_i  input  HOLD_W  pipeline hold level.
REQ-013 fetch_ready_i  input  1  fetch side accepts pc_o this cycle.
REQ-014 compressed_i  input  1  instruction at pc_o is 16-bit; ignored when C_EXT=0.
REQ-015 pc_o  output  ADDR_W  current fetch PC (registered).
REQ-016 fetch_valid_o  output  1  pc_o is a valid fetch request.
REQ-017 flush_o  output  1  registered one-cycle pulse after an accepted redirect.
REQ-018 misalign_o  output  1  sticky misaligned-target flag.
REQ-019 misalign_addr_o  output  ADDR_W  captured misaligned target.

Function
REQ-020 FSM states are BOOT, RUN and HALT.
REQ-021 fetch_valid_o SHALL be combinational: 1 only when state==RUN and hold_flag_i < HOLD_PC_LVL.
REQ-022 Selected redirect is the lowest-index asserted channel; other channels are ignored that cycle.
REQ-023 A target is misaligned when addr[1:0]!=0 (C_EXT=0) or addr[0]!=0 (C_EXT=1).
REQ-024 Per-cycle priority in RUN: aligned redirect (pc_o<=target) > misaligned redirect > hold (pc_o kept) > handshake (fetch_valid_o && fetch_ready_i advances pc_o) > keep pc_o.
REQ-025 Redirect overrides hold and the handshake in the same cycle.
REQ-026 Advance step is 2 when C_EXT=1 and compressed_i=1, else 4; the sum wraps modulo 2^ADDR_W.
REQ-027 Misaligned redirect (BOOT or RUN): pc_o unchanged, misalign_o<=1, misalign_addr_o<=target, next state HALT; flush_o not pulsed.
REQ-028 HALT: fetch_valid_o=0 and pc_o frozen; an aligned redirect loads pc_o, clears misalign_o and moves to RUN; a misaligned redirect recaptures misalign_addr_o and stays in HALT.
REQ-029 BOOT: a counter runs from 0; state moves to RUN after BOOT_CYCLES cycles; an aligned redirect in BOOT loads pc_o without restarting the counter.
REQ-030 flush_o=1 exactly in the cycle after any accepted aligned redirect in any state; otherwise 0.
REQ-031 With NUM_REDIR=1, HOLD_PC_LVL=1, C_EXT=0 and BOOT_CYCLES=0, behaviour SHALL match a plain jump/hold/+4 PC register.

Reset
REQ-032 On rst=1 at a clock edge: pc_o=RESET_VEC, flush_o=0, misalign_o=0, misalign_addr_o=0, boot counter=0.
REQ-033 On rst=1 at a clock edge, state=BOOT, or RUN when BOOT_CYCLES=0.
REQ-034 rst SHALL dominate all other inputs, including mid-HALT and mid-BOOT.

Structure
REQ-035 Package pc_gen_pkg holds the FSM state encoding, the step constants (2 and 4) and the default hold-level constant.
REQ-036 One sub-module, redir_arbiter, SHALL implement the fixed-priority select and target mux (output: valid and address).

Verification
REQ-037 Reset, BOOT_CYCLES=2, ready=1 -> pc_o=0 and fetch_valid_o=0 for 2 cycles, then pc_o steps 0,4,8.
REQ-038 RUN at pc 0x10, redir_valid=2'b11 with targets 0x100/0x200, hold=3 -> pc_o=0x100, then flush_o=1 for exactly one cycle.
REQ-039 C_EXT=1, pc 0x20, compressed_i=1,0 with ready=1 -> pc_o sequence 0x22, 0x26; pc 0xFFFFFFFC +4 -> 0x0.
REQ-040 C_EXT=0, redirect to 0x102 -> HALT, misalign_o=1, misalign_addr_o=0x102, pc frozen; then redirect to 0x200 -> RUN, pc_o=0x200, misalign_o=0.
REQ-041 hold=1 with ready=1 for 3 cycles -> pc_o constant and fetch_valid_o=0; rst=1 in HALT -> pc_o=RESET_VEC, state BOOT.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch PC generator: FSM encoding,
// PC step sizes and the default hold level.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam int STEP_2         = 2;
    localparam int STEP_4         = 4;
    localparam int HOLD_LVL_DEF   = 1;

    // With 16-bit instructions only halfword alignment is required.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input bit c_ext);
        return c_ext ? addr_lo[0] : (|addr_lo);
    endfunction

endpackage

// File: rtl/pc_gen_redir_arbiter.sv
// Fixed-priority redirect select: the lowest-index asserted channel wins
// and its target is forwarded.
module redir_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int NUM_REDIR = 2
) (
    input  logic [NUM_REDIR-1:0]        valid_i,
    input  logic [NUM_REDIR*ADDR_W-1:0] addr_i,
    output logic                        valid_o,
    output logic [ADDR_W-1:0]           addr_o
);

    logic [NUM_REDIR:0]   lower_taken;
    logic [NUM_REDIR-1:0] grant;

    assign lower_taken[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NUM_REDIR; gi++) begin : g_prio
            assign grant[gi]           = valid_i[gi] & ~lower_taken[gi];
            assign lower_taken[gi + 1] = lower_taken[gi] | valid_i[gi];
        end
    endgenerate

    assign valid_o = lower_taken[NUM_REDIR];

    // Grant is one-hot, so an OR of masked targets is a mux.
    always_comb begin
        addr_o = '0;
        for (int k = 0; k < NUM_REDIR; k++) begin
            if (grant[k]) begin
                addr_o = addr_o | addr_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: boot delay, prioritised redirects, hold and
// handshake-driven stepping, with a sticky misaligned-target trap.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = 32'h0,
    parameter int                NUM_REDIR   = 2,
    parameter int                HOLD_W      = 3,
    parameter int                HOLD_PC_LVL = HOLD_LVL_DEF,
    parameter bit                C_EXT       = 1'b0,
    parameter int                BOOT_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REDIR-1:0]        redir_valid_i,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_addr_i,
    input  logic [HOLD_W-1:0]           hold_flag_i,
    input  logic                        fetch_ready_i,
    input  logic                        compressed_i,
    output logic [ADDR_W-1:0]           pc_o,
    output logic                        fetch_valid_o,
    output logic                        flush_o,
    output logic                        misalign_o,
    output logic [ADDR_W-1:0]           misalign_addr_o
);

    localparam int                CNT_W     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  BOOT_LAST = CNT_W'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);
    localparam pc_state_e         RST_STATE = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;
    localparam logic [HOLD_W:0]   HOLD_LVL  = (HOLD_W + 1)'(HOLD_PC_LVL);

    pc_state_e         state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              flush_q;
    logic              misalign_q;
    logic [ADDR_W-1:0] misalign_addr_q;
    logic [CNT_W-1:0]  boot_cnt_q;

    logic              redir_valid;
    logic [ADDR_W-1:0] redir_addr;
    logic              redir_bad;
    logic              held;

    redir_arbiter #(
        .ADDR_W    (ADDR_W),
        .NUM_REDIR (NUM_REDIR)
    ) u_arb (
        .valid_i (redir_valid_i),
        .addr_i  (redir_addr_i),
        .valid_o (redir_valid),
        .addr_o  (redir_addr)
    );

    assign redir_bad     = is_misaligned(redir_addr[1:0], C_EXT);
    assign held          = ({1'b0, hold_flag_i} >= HOLD_LVL);
    assign fetch_valid_o = (state_q == ST_RUN) && !held;
    assign pc_d          = pc_q + ((C_EXT && compressed_i) ? ADDR_W'(STEP_2) : ADDR_W'(STEP_4));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RST_STATE;
            pc_q            <= RESET_VEC;
            flush_q         <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
            boot_cnt_q      <= '0;
        end else begin
            flush_q <= 1'b0;
            // The boot counter keeps running even when a redirect lands in BOOT.
            if (state_q == ST_BOOT) begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_q <= ST_RUN;
                end else begin
                    boot_cnt_q <= boot_cnt_q + 1'b1;
                end
            end
            if (redir_valid) begin
                if (!redir_bad) begin
                    pc_q       <= redir_addr;
                    flush_q    <= 1'b1;
                    misalign_q <= 1'b0;
                    if (state_q == ST_HALT) begin
                        state_q <= ST_RUN;
                    end
                end else begin
                    misalign_q      <= 1'b1;
                    misalign_addr_q <= redir_addr;
                    state_q         <= ST_HALT;
                end
            end else if (fetch_valid_o && fetch_ready_i) begin
                pc_q <= pc_d;
            end
        end
    end

    assign pc_o            = pc_q;
    assign flush_o         = flush_q;
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = misalign_addr_q;

endmodule
